// File: rtl/ps_inspect_pkg.sv
// Shared constants and helpers for the PS clock inspection blocks.
package ps_inspect_pkg;

    localparam int unsigned NUM_CLKS        = 4;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_GATE_CYCLES = 1000;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/clk_edge_counter.sv
// One measurement channel: synchronizer, rising-edge detect, saturating accumulator and
// per-window result registers (count, stuck, ovf).
module clk_edge_counter
    import ps_inspect_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ila_clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             enable,
    input  logic             terminal,
    output logic [CNT_W-1:0] count,
    output logic             stuck,
    output logic             ovf
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   stuck_q, stuck_d;
    logic                   ovf_q, ovf_d;

    logic             settled, rise_en;
    logic [CNT_W-1:0] acc_next;
    logic             ovf_next;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], div_clk};
        prev_d   = sync_q[SYNC_STAGES-1];
        // prev only holds a real synchronized sample once the reset zeros have flushed through
        settled  = (settle_q == SETTLE_DONE);
        settle_d = settled ? settle_q : settle_q + SETTLE_W'(1);
        rise_en  = sync_q[SYNC_STAGES-1] & ~prev_q & settled & enable;

        acc_next = rise_en ? CNT_W'(sat_inc(32'(acc_q), CNT_W)) : acc_q;
        ovf_next = ovf_acc_q | (rise_en & (acc_q == CNT_MAX));

        count_d   = count_q;
        stuck_d   = stuck_q;
        ovf_d     = ovf_q;
        acc_d     = acc_next;
        ovf_acc_d = ovf_next;
        if (terminal) begin
            count_d   = acc_next;
            stuck_d   = (acc_next == '0);
            ovf_d     = ovf_next;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
        end
    end

    always_ff @(posedge ila_clk) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            settle_q  <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            count_q   <= '0;
            stuck_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            count_q   <= count_d;
            stuck_q   <= stuck_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count = count_q;
    assign stuck = stuck_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/ps_clk_meter.sv
// Gated-window frequency meter for the four prescaled PS clocks, all logic on ila_clk.
// Optional per-channel min/max tracking is built when PS_CLK_METER_MINMAX_EN is defined.
module ps_clk_meter
    import ps_inspect_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      ila_clk,
    input  logic                      rst,
    input  logic [NUM_CLKS-1:0]       div_clk,
    input  logic                      enable,
    output logic [NUM_CLKS*CNT_W-1:0] count,
    output logic                      count_vld,
    output logic [NUM_CLKS-1:0]       stuck,
`ifdef PS_CLK_METER_MINMAX_EN
    output logic [NUM_CLKS-1:0]       ovf,
    output logic [NUM_CLKS*CNT_W-1:0] cnt_min,
    output logic [NUM_CLKS*CNT_W-1:0] cnt_max
`else
    output logic [NUM_CLKS-1:0]       ovf
`endif
);

    localparam int unsigned WIN_W = $clog2(GATE_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             count_vld_q, count_vld_d;
    logic             terminal;

    always_comb begin
        terminal    = enable & (win_cnt_q == WIN_LAST);
        count_vld_d = terminal;
        win_cnt_d   = win_cnt_q;
        if (terminal) begin
            win_cnt_d = '0;
        end else if (enable) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    always_ff @(posedge ila_clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            count_vld_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            count_vld_q <= count_vld_d;
        end
    end

    assign count_vld = count_vld_q;

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        clk_edge_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_counter (
            .ila_clk  (ila_clk),
            .rst      (rst),
            .div_clk  (div_clk[g]),
            .enable   (enable),
            .terminal (terminal),
            .count    (count[g*CNT_W +: CNT_W]),
            .stuck    (stuck[g]),
            .ovf      (ovf[g])
        );
    end

`ifdef PS_CLK_METER_MINMAX_EN
    logic [NUM_CLKS*CNT_W-1:0] cnt_min_q, cnt_min_d;
    logic [NUM_CLKS*CNT_W-1:0] cnt_max_q, cnt_max_d;

    // Folds in the freshly published window, so trails count_vld by one cycle.
    always_comb begin
        cnt_min_d = cnt_min_q;
        cnt_max_d = cnt_max_q;
        if (count_vld_q) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                if (count[i*CNT_W +: CNT_W] < cnt_min_q[i*CNT_W +: CNT_W]) begin
                    cnt_min_d[i*CNT_W +: CNT_W] = count[i*CNT_W +: CNT_W];
                end
                if (count[i*CNT_W +: CNT_W] > cnt_max_q[i*CNT_W +: CNT_W]) begin
                    cnt_max_d[i*CNT_W +: CNT_W] = count[i*CNT_W +: CNT_W];
                end
            end
        end
    end

    always_ff @(posedge ila_clk) begin
        if (rst) begin
            cnt_min_q <= '1;
            cnt_max_q <= '0;
        end else begin
            cnt_min_q <= cnt_min_d;
            cnt_max_q <= cnt_max_d;
        end
    end

    assign cnt_min = cnt_min_q;
    assign cnt_max = cnt_max_q;
`endif

endmodule
